hm2_idrom_responder: RTL and testbench

- Bus-slave responder that serves the board-identity constants (board name, clocks, FPGA size, I/O geometry, LED count, GPIO layout) to the HostMot2 host over the internal register bus.
- Is the read-side consumer of the board-type constants and sits beside the hostmot2 core on the same bus as the other register slaves.
- Adds programmable wait states, out-of-range error signalling and a saturating read counter that the host can clear.

---
 rtl/hm2_idrom_responder.sv | 156 +++++++++++++++
 tb/tb_hm2_idrom_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hm2_idrom_responder.sv
// HostMot2 IDROM responder: serves board identity constants over the register bus.
// Programmable wait states, out-of-range error flag and a clearable read counter.
module hm2_idrom_responder #(
    parameter int                   BusWidth      = 32,
    parameter int                   AddrWidth     = 16,
    parameter logic [AddrWidth-1:0] BaseAddr      = 16'h0100,
    parameter int                   WaitStates    = 1,
    parameter logic [31:0]          BoardNameLow  = 32'h4153454D,
    parameter logic [31:0]          BoardNameHigh = 32'h35324935,
    parameter int                   FPGASize      = 9,
    parameter int                   FPGAPins      = 144,
    parameter int                   IOPorts       = 4,
    parameter int                   IOWidth       = 68,
    parameter int                   PortWidth     = 17,
    parameter int                   ClockLow      = 50000000,
    parameter int                   ClockHigh     = 200000000,
    parameter int                   LIOWidth      = 6,
    parameter int                   LEDCount      = 4,
    parameter int                   GPIOWidth     = 36,
    parameter int                   NumGPIO       = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AddrWidth-1:0] addr,
    input  logic                 rd_req,
    input  logic                 wr_req,
    input  logic [BusWidth-1:0]  wdata,
    output logic                 ready,
    output logic                 rvalid,
    output logic [BusWidth-1:0]  rdata,
    output logic                 rerr
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] WaitLoad  = 4'(WaitStates - 1);
    localparam logic [3:0] CountIdx  = 4'd12;
    localparam bit         NoWait    = (WaitStates == 0);

    logic [1:0]  state;
    logic [3:0]  wcnt;
    logic [3:0]  idx_q;
    logic        rd_q;
    logic [15:0] rdcount;

    logic          sel;
    logic          accept;
    logic          go_resp;
    logic [3:0]    idx_src;
    logic          rd_src;
    logic [31:0]   map_val;
    logic [BusWidth-1:0] resp_data;
    logic          resp_err;
    logic          unused_wdata;

    assign unused_wdata = ^wdata;

    assign sel    = (addr[AddrWidth-1:4] == BaseAddr[AddrWidth-1:4]);
    assign accept = (rd_req | wr_req) & sel & (state == IDLE);
    assign ready  = (state == IDLE);
    assign rvalid = (state == RESP);

    assign go_resp = (accept && NoWait) ||
                     (state == WAIT && wcnt == 4'd0);

    // Zero-wait responses are built straight from the bus; otherwise from latched request
    always_comb begin
        idx_src = idx_q;
        rd_src  = rd_q;
        if (state == IDLE) begin
            idx_src = addr[3:0];
            rd_src  = rd_req;
        end
    end

    always_comb begin
        map_val = 32'h0;
        case (idx_src)
            4'd0:    map_val = BoardNameLow;
            4'd1:    map_val = BoardNameHigh;
            4'd2:    map_val = 32'(FPGASize);
            4'd3:    map_val = 32'(FPGAPins);
            4'd4:    map_val = 32'(IOPorts);
            4'd5:    map_val = 32'(IOWidth);
            4'd6:    map_val = 32'(PortWidth);
            4'd7:    map_val = 32'(ClockLow);
            4'd8:    map_val = 32'(ClockHigh);
            4'd9:    map_val = 32'(LIOWidth);
            4'd10:   map_val = 32'(LEDCount);
            4'd11:   map_val = {16'(NumGPIO), 16'(GPIOWidth)};
            4'd12:   map_val = {16'h0, rdcount};
            default: map_val = 32'h0;
        endcase
    end

    always_comb begin
        resp_data = '0;
        resp_err  = 1'b0;
        if (rd_src) begin
            if (idx_src <= CountIdx) resp_data = BusWidth'(map_val);
            else                     resp_err  = 1'b1;
        end else begin
            resp_err = (idx_src != CountIdx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            wcnt    <= 4'd0;
            idx_q   <= 4'd0;
            rd_q    <= 1'b0;
            rdcount <= 16'd0;
            rdata   <= '0;
            rerr    <= 1'b0;
        end else begin
            rdata <= '0;
            rerr  <= 1'b0;
            if (go_resp) begin
                rdata <= resp_data;
                rerr  <= resp_err;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        idx_q <= addr[3:0];
                        rd_q  <= rd_req;
                        if (NoWait) begin
                            state <= RESP;
                        end else begin
                            wcnt  <= WaitLoad;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wcnt == 4'd0) state <= RESP;
                    else              wcnt  <= wcnt - 4'd1;
                end
                RESP: begin
                    state <= IDLE;
                    // Counter settles at the end of the response so idx 12 reports the old value
                    if (rd_q && idx_q <= CountIdx) begin
                        if (rdcount != 16'hFFFF) rdcount <= rdcount + 16'd1;
                    end else if (!rd_q && idx_q == CountIdx) begin
                        rdcount <= 16'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hm2_idrom_responder.sv
// Bench for hm2_idrom_responder: vector table, corner sequences and random traffic
// against a register-map model, on a zero-wait and a three-wait instance.
module tb_hm2_idrom_responder;

    logic        clk;
    logic        reset;
    logic [15:0] addr_s  [2];
    logic        rd_s    [2];
    logic        wr_s    [2];
    logic [31:0] wdata_s [2];
    logic        ready_s [2];
    logic        rvalid_s[2];
    logic [31:0] rdata_s [2];
    logic        rerr_s  [2];

    int checks = 0;
    int errors = 0;
    int ws_of [2] = '{0, 3};

    logic [31:0] rom [12] = '{
        32'h4153454D, 32'h35324935, 32'd9, 32'd144, 32'd4, 32'd68,
        32'd17, 32'd50000000, 32'd200000000, 32'd6, 32'd4, 32'h00020024
    };
    logic [15:0] cnt [2];

    hm2_idrom_responder #(.WaitStates(0)) u0 (
        .clk(clk), .reset(reset), .addr(addr_s[0]),
        .rd_req(rd_s[0]), .wr_req(wr_s[0]), .wdata(wdata_s[0]),
        .ready(ready_s[0]), .rvalid(rvalid_s[0]),
        .rdata(rdata_s[0]), .rerr(rerr_s[0])
    );

    hm2_idrom_responder #(.WaitStates(3)) u3 (
        .clk(clk), .reset(reset), .addr(addr_s[1]),
        .rd_req(rd_s[1]), .wr_req(wr_s[1]), .wdata(wdata_s[1]),
        .ready(ready_s[1]), .rvalid(rvalid_s[1]),
        .rdata(rdata_s[1]), .rerr(rerr_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: register map plus counter rules, one call per request
    task automatic model(input int w, input logic [15:0] a,
                         input logic rd, input logic wr,
                         output logic v, output logic [31:0] d,
                         output logic e);
        int idx;
        idx = int'(a[3:0]);
        v = 1'b0; d = 32'h0; e = 1'b0;
        if (a[15:4] == 12'h010 && (rd || wr)) begin
            v = 1'b1;
            if (rd) begin
                if (idx < 13) begin
                    d = (idx == 12) ? {16'h0, cnt[w]} : rom[idx];
                    if (cnt[w] != 16'hFFFF) cnt[w] = cnt[w] + 16'd1;
                end else begin
                    e = 1'b1;
                end
            end else begin
                e = (idx != 12);
                if (idx == 12) cnt[w] = 16'd0;
            end
        end
    endtask

    task automatic idle_bus(input int w);
        addr_s[w] = 16'h0000;
        rd_s[w]   = 1'b0;
        wr_s[w]   = 1'b0;
        wdata_s[w] = 32'h0;
    endtask

    task automatic do_txn(input int w, input logic [15:0] a,
                          input logic rd, input logic wr,
                          input logic ev, input logic [31:0] ed,
                          input logic ee, input logic scramble,
                          input string nm);
        int ws;
        ws = ws_of[w];
        @(negedge clk);
        addr_s[w]  = a;
        rd_s[w]    = rd;
        wr_s[w]    = wr;
        wdata_s[w] = $urandom;
        @(posedge clk);
        #1;
        rd_s[w] = 1'b0;
        wr_s[w] = 1'b0;
        if (scramble) addr_s[w] = 16'h0100;
        if (!ev) begin
            for (int c = 0; c < 3; c++) begin
                chk({nm, " unsel rvalid"}, 32'(rvalid_s[w]), 32'd0);
                chk({nm, " unsel ready"}, 32'(ready_s[w]), 32'd1);
                @(posedge clk);
                #1;
            end
        end else begin
            for (int c = 1; c <= ws; c++) begin
                chk({nm, " wait rvalid"}, 32'(rvalid_s[w]), 32'd0);
                chk({nm, " wait ready"}, 32'(ready_s[w]), 32'd0);
                @(posedge clk);
                #1;
            end
            chk({nm, " rvalid"}, 32'(rvalid_s[w]), 32'd1);
            chk({nm, " ready busy"}, 32'(ready_s[w]), 32'd0);
            chk({nm, " rdata"}, rdata_s[w], ed);
            chk({nm, " rerr"}, 32'(rerr_s[w]), 32'(ee));
            @(posedge clk);
            #1;
            chk({nm, " rvalid off"}, 32'(rvalid_s[w]), 32'd0);
            chk({nm, " ready back"}, 32'(ready_s[w]), 32'd1);
            chk({nm, " rdata clr"}, rdata_s[w], 32'd0);
        end
        idle_bus(w);
    endtask

    task automatic model_txn(input int w, input logic [15:0] a,
                             input logic rd, input logic wr,
                             input logic scramble, input string nm);
        logic v;
        logic [31:0] d;
        logic e;
        model(w, a, rd, wr, v, d, e);
        do_txn(w, a, rd, wr, v, d, e, scramble, nm);
    endtask

    typedef struct {
        int          w;
        logic [15:0] a;
        logic        rd;
        logic        wr;
        logic        scr;
        logic        ev;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    vec_t vecs [22];

    initial begin
        logic v;
        logic [31:0] d;
        logic e;
        vecs = '{
            '{0, 16'h0100, 1, 0, 0, 1, 32'h4153454D, 0},
            '{0, 16'h0107, 1, 0, 0, 1, 32'h02FAF080, 0},
            '{0, 16'h010D, 1, 0, 0, 1, 32'h0, 1},
            '{0, 16'h0200, 1, 0, 0, 0, 32'h0, 0},
            '{0, 16'h0103, 0, 1, 0, 1, 32'h0, 1},
            '{0, 16'h0102, 1, 0, 0, 1, 32'd9, 0},
            '{0, 16'h0103, 1, 0, 0, 1, 32'd144, 0},
            '{0, 16'h010B, 1, 0, 0, 1, 32'h00020024, 0},
            '{0, 16'h010C, 1, 0, 0, 1, 32'd5, 0},
            '{0, 16'h010C, 1, 0, 0, 1, 32'd6, 0},
            '{0, 16'h010C, 1, 1, 0, 1, 32'd7, 0},
            '{0, 16'h010C, 1, 0, 0, 1, 32'd8, 0},
            '{0, 16'h010C, 0, 1, 0, 1, 32'h0, 0},
            '{0, 16'h010C, 1, 0, 0, 1, 32'd0, 0},
            '{1, 16'h0101, 1, 0, 1, 1, 32'h35324935, 0},
            '{1, 16'h0108, 1, 0, 1, 1, 32'h0BEBC200, 0},
            '{1, 16'h010F, 1, 0, 0, 1, 32'h0, 1},
            '{1, 16'h010C, 1, 0, 1, 1, 32'd2, 0},
            '{0, 16'h0109, 1, 0, 0, 1, 32'd6, 0},
            '{0, 16'h010A, 1, 0, 0, 1, 32'd4, 0},
            '{1, 16'h0105, 1, 0, 0, 1, 32'd68, 0},
            '{1, 16'h0106, 1, 0, 0, 1, 32'd17, 0}
        };
        idle_bus(0);
        idle_bus(1);
        cnt[0] = 16'd0;
        cnt[1] = 16'd0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            chk("reset ready", 32'(ready_s[w]), 32'd1);
            chk("reset rvalid", 32'(rvalid_s[w]), 32'd0);
            chk("reset rdata", rdata_s[w], 32'd0);
            chk("reset rerr", 32'(rerr_s[w]), 32'd0);
        end

        for (int i = 0; i < 22; i++) begin
            do_txn(vecs[i].w, vecs[i].a, vecs[i].rd, vecs[i].wr,
                   vecs[i].ev, vecs[i].ed, vecs[i].ee, vecs[i].scr,
                   $sformatf("vec%0d", i));
            model(vecs[i].w, vecs[i].a, vecs[i].rd, vecs[i].wr, v, d, e);
        end

        // Saturation: preload near the top, then read past it
        @(negedge clk);
        force u0.rdcount = 16'hFFFD;
        @(negedge clk);
        release u0.rdcount;
        cnt[0] = 16'hFFFD;
        for (int i = 0; i < 3; i++) model_txn(0, 16'h0100, 1, 0, 0, "sat rd");
        model_txn(0, 16'h010C, 1, 0, 0, "sat cnt");
        model_txn(0, 16'h010C, 1, 0, 0, "sat hold");

        // Reset while the three-wait instance sits in WAIT
        @(negedge clk);
        addr_s[1] = 16'h0100;
        rd_s[1]   = 1'b1;
        @(posedge clk);
        #1;
        idle_bus(1);
        chk("abort in wait", 32'(ready_s[1]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cnt[0] = 16'd0;
        cnt[1] = 16'd0;
        chk("abort ready", 32'(ready_s[1]), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("abort no rvalid", 32'(rvalid_s[1]), 32'd0);
        end
        model_txn(1, 16'h010C, 1, 0, 0, "abort cnt");

        for (int i = 0; i < 200; i++) begin
            int w;
            int op;
            logic [15:0] a;
            w  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0)
                a = 16'h0100 | 16'($urandom_range(0, 15));
            else
                a = 16'h0200 + 16'($urandom_range(0, 16'h3FF));
            model_txn(w, a, op != 1, op == 1 || op == 2,
                      1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
